neural_hs_ctrl: RTL and testbench

FPGA-side handshake controller between the SoC software PIO ports and the neural-network datapath. Software issues LOAD, START and READ commands over a 2-bit command PIO with a 32-bit data PIO. The block sequences weight/input writes into the datapath, pulses compute start and tracks busy. It also buffers datapath results in a small FIFO that software drains through a 32-bit read PIO and a 2-bit status PIO.

---
 rtl/neural_hs_ctrl.sv | 126 ++++++++++++
 tb/tb_neural_hs_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/neural_hs_ctrl.sv
// neural_hs_ctrl: SW PIO command handshake to NN datapath with result FIFO; optional watchdog via NEURAL_HS_TIMEOUT_EN
module neural_hs_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [1:0]        sw_cmd,
  input  logic [31:0]       sw_wdata,
  output logic [1:0]        sw_status,
  output logic [31:0]       sw_rdata,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              nn_start,
  input  logic              nn_done,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [31:0]       res_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, READ_WAIT, ACK} state_t;
  state_t        state;
  logic [1:0]    cmd_q;
  logic [31:0]   wdata_q;
  logic          ack, busy;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   cnt;
  logic          empty, push, pop, tmo;
  assign empty     = cnt == '0;
  assign res_ready = cnt != (PW+1)'(FIFO_DEPTH);
  assign push      = res_valid & res_ready;
  assign pop       = !empty && ((state == IDLE && cmd_q == 2'b11) || state == READ_WAIT);
  assign sw_status = {busy, ack};
`ifdef NEURAL_HS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  assign tmo = tmo_cnt == TW'(TIMEOUT_CYCLES);
  // watchdog counts cycles spent waiting; any other state clears it so each wait starts from zero
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) tmo_cnt <= '0;
    else tmo_cnt <= ((state == LOAD_WAIT || state == READ_WAIT) && !tmo) ? tmo_cnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  // command sequencer: registers the PIO inputs and drives all handshake outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      wdata_q  <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      sw_rdata <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      nn_start <= 1'b0;
    end else begin
      cmd_q    <= sw_cmd;
      wdata_q  <= sw_wdata;
      nn_start <= 1'b0;
      if (nn_done) busy <= 1'b0;
      case (state)
        IDLE: case (cmd_q)
          2'b01: begin
            wr_data  <= wdata_q;
            wr_valid <= 1'b1;
            state    <= LOAD_WAIT;
          end
          2'b10: begin
            if (!busy) begin
              nn_start <= 1'b1;
              busy     <= 1'b1;
              wr_addr  <= '0;
            end
            ack   <= 1'b1;
            state <= ACK;
          end
          2'b11: if (!empty) begin
            sw_rdata <= mem[rptr];
            ack      <= 1'b1;
            state    <= ACK;
          end else state <= READ_WAIT;
          default: ;
        endcase
        LOAD_WAIT: if (wr_ready) begin
          wr_valid <= 1'b0;
          wr_addr  <= wr_addr + 1'b1;
          ack      <= 1'b1;
          state    <= ACK;
        end else if (tmo) begin
          wr_valid <= 1'b0;
          sw_rdata <= 32'hDEAD_BEEF;
          ack      <= 1'b1;
          state    <= ACK;
        end
        READ_WAIT: if (!empty || tmo) begin
          sw_rdata <= !empty ? mem[rptr] : 32'hDEAD_BEEF;
          ack      <= 1'b1;
          state    <= ACK;
        end
        ACK: if (cmd_q == 2'b00) begin
          ack   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  // result FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  // result storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk_clk)
    if (push) mem[wptr] <= res_data;
endmodule

// File: tb/tb_neural_hs_ctrl.sv
// tb_neural_hs_ctrl: directed self-checking bench for neural_hs_ctrl
module tb_neural_hs_ctrl;
  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [1:0]  sw_cmd = '0;
  logic [31:0] sw_wdata = '0;
  logic [1:0]  sw_status;
  logic [31:0] sw_rdata;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        nn_start;
  logic        nn_done = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] res_data = '0;
  int n_chk = 0, n_err = 0, n_wr = 0, n_start = 0, n_dbl = 0;
  logic prev_start = 1'b0;
  neural_hs_ctrl #(
`ifdef NEURAL_HS_TIMEOUT_EN
    .TIMEOUT_CYCLES(16)
`else
    .TIMEOUT_CYCLES(1024)
`endif
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .sw_cmd(sw_cmd), .sw_wdata(sw_wdata),
    .sw_status(sw_status), .sw_rdata(sw_rdata), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .nn_start(nn_start), .nn_done(nn_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );
  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) begin
    if (wr_valid && wr_ready) n_wr++;
    if (nn_start) n_start++;
    if (nn_start && prev_start) n_dbl++;
    prev_start <= nn_start;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask
  task automatic release_ack();
    sw_cmd = 2'b00;
    step(1);
    chk("ack_hold", 32'(sw_status[0]), 1);
    step(1);
    chk("ack_fall", 32'(sw_status[0]), 0);
  endtask
  task automatic do_load(input logic [31:0] d, input logic [31:0] a);
    sw_cmd = 2'b01;
    sw_wdata = d;
    step(2);
    chk("load_valid", 32'(wr_valid), 1);
    chk("load_addr", 32'(wr_addr), a);
    chk("load_data", wr_data, d);
    chk("load_noack", 32'(sw_status[0]), 0);
    step(1);
    chk("load_ack", 32'(sw_status[0]), 1);
    chk("load_drop", 32'(wr_valid), 0);
    release_ack();
  endtask
  task automatic do_read(input logic [31:0] exp);
    sw_cmd = 2'b11;
    step(2);
    chk("read_ack", 32'(sw_status[0]), 1);
    chk("read_data", sw_rdata, exp);
    release_ack();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step(3);
    chk("rst_status", 32'(sw_status), 0);
    chk("rst_rdata", sw_rdata, 0);
    chk("rst_valid", 32'(wr_valid), 0);
    chk("rst_res_ready", 32'(res_ready), 1);
    reset_reset_n = 1'b1;
    step(2);
    do_load(32'h11, 0);
    do_load(32'h22, 1);
    do_load(32'h33, 2);
    wr_ready = 1'b0;
    sw_cmd = 2'b01;
    sw_wdata = 32'h44;
    step(2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(wr_valid), 1);
      chk("stall_data", wr_data, 32'h44);
      chk("stall_noack", 32'(sw_status[0]), 0);
      step(1);
    end
    chk("stall_valid6", 32'(wr_valid), 1);
    wr_ready = 1'b1;
    step(1);
    chk("stall_ack", 32'(sw_status[0]), 1);
    chk("stall_addr", 32'(wr_addr), 4);
    release_ack();
    chk("write_count", n_wr, 4);
    sw_cmd = 2'b10;
    step(1);
    chk("start_busy_e0", 32'(sw_status[1]), 0);
    step(1);
    chk("start_pulse", 32'(nn_start), 1);
    chk("start_busy", 32'(sw_status[1]), 1);
    chk("start_ack", 32'(sw_status[0]), 1);
    chk("start_addr0", 32'(wr_addr), 0);
    release_ack();
    sw_cmd = 2'b10;
    step(2);
    chk("start2_ack", 32'(sw_status[0]), 1);
    chk("start2_nopulse", 32'(nn_start), 0);
    release_ack();
    step(14);
    nn_done = 1'b1;
    chk("busy_before_done", 32'(sw_status[1]), 1);
    step(1);
    nn_done = 1'b0;
    chk("busy_cleared", 32'(sw_status[1]), 0);
    chk("start_count", n_start, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("fifo_ready", 32'(res_ready), 1);
      res_valid = 1'b1;
      res_data = 32'(i);
      step(1);
    end
    res_valid = 1'b0;
    chk("fifo_full", 32'(res_ready), 0);
    for (int i = 1; i <= 8; i++) do_read(32'(i));
    chk("fifo_drained", 32'(res_ready), 1);
    sw_cmd = 2'b11;
    step(10);
`ifdef NEURAL_HS_TIMEOUT_EN
    for (int i = 0; i < 40 && !sw_status[0]; i++) step(1);
    chk("tmo_ack", 32'(sw_status[0]), 1);
    chk("tmo_data", sw_rdata, 32'hDEAD_BEEF);
    release_ack();
    sw_cmd = 2'b11;
    step(3);
`endif
    chk("rdwait_noack", 32'(sw_status[0]), 0);
    res_valid = 1'b1;
    res_data = 32'hCAFE;
    step(1);
    res_valid = 1'b0;
    chk("rdwait_push_noack", 32'(sw_status[0]), 0);
    step(1);
    chk("rdwait_ack", 32'(sw_status[0]), 1);
    chk("rdwait_data", sw_rdata, 32'hCAFE);
    release_ack();
    do_load(32'h55, 0);
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1;
      res_data = 32'(i + 100);
      step(1);
    end
    res_valid = 1'b0;
    wr_ready = 1'b0;
    sw_cmd = 2'b01;
    sw_wdata = 32'h66;
    step(2);
    chk("pre_rst_valid", 32'(wr_valid), 1);
    reset_reset_n = 1'b0;
    sw_cmd = 2'b00;
    #1;
    chk("arst_valid", 32'(wr_valid), 0);
    chk("arst_addr", 32'(wr_addr), 0);
    chk("arst_data", wr_data, 0);
    chk("arst_rdata", sw_rdata, 0);
    chk("arst_status", 32'(sw_status), 0);
    chk("arst_res_ready", 32'(res_ready), 1);
    step(2);
    reset_reset_n = 1'b1;
    wr_ready = 1'b1;
    step(1);
    sw_cmd = 2'b11;
    step(6);
    chk("post_rst_read_waits", 32'(sw_status[0]), 0);
    chk("no_double_start", n_dbl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
